mini_risc_ctrl_fsm: RTL and testbench

- Multi-cycle control unit for the KGP mini-RISC core.
- Consumes `opcode_out` and `func_out` from `data_path`. Drives every `data_path` control input: `reg_write`, muxes, `alu_op`, dmem enables and `br_op`.
- Also drives two new `data_path` strobes, `ir_write` and `pc_write`. These sequence each instruction through fetch, decode, execute, memory and writeback.

---
 rtl/mini_risc_ctrl_fsm.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mini_risc_ctrl_fsm.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mini_risc_ctrl_fsm.sv
// Multi-cycle control unit for the KGP mini-RISC core.
// Sequences each instruction through fetch, decode, execute, memory and
// writeback, and drives every data_path control input from registered flops.
// Optional build macro: ILLEGAL_OP_TRAP_EN (trap undefined opcodes / R-type
// func > 7 into S_HALT and raise a sticky illegal_op flag). When the macro is
// not defined, such instructions retire as a NOP.
module mini_risc_ctrl_fsm #(
    parameter int unsigned MEM_LAT     = 1,          // legal range 1..7
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode_out,
    input  logic [5:0] func_out,
    output logic [1:0] reg_write,
    output logic       imm_mux_ctrl,
    output logic       alu_mux_ctrl,
    output logic [3:0] alu_op,
    output logic       dmem_enable,
    output logic       dmem_write_enable,
    output logic [1:0] reg_write_mux_ctrl,
    output logic [4:0] br_op,
    output logic       ir_write,
    output logic       pc_write,
    output logic       halted,
    output logic [2:0] state_out
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic       illegal_op
`endif
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned CNT_W = 3;

    localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_LAT - 1);

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b000001;
    localparam logic [OP_W-1:0] OP_COMPI = 6'b000010;
    localparam logic [OP_W-1:0] OP_LW    = 6'b000011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b000100;
    localparam logic [OP_W-1:0] OP_B     = 6'b000101;
    localparam logic [OP_W-1:0] OP_BL    = 6'b001010;
    localparam logic [OP_W-1:0] OP_BNCY  = 6'b001100;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd7
    } state_e;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [OP_W-1:0]   func_q, func_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              illegal_q, illegal_d;

    logic [1:0] reg_write_q, reg_write_d;
    logic       imm_mux_q, imm_mux_d;
    logic       alu_mux_q, alu_mux_d;
    logic [3:0] alu_op_q, alu_op_d;
    logic       dmem_en_q, dmem_en_d;
    logic       dmem_we_q, dmem_we_d;
    logic [1:0] rw_mux_q, rw_mux_d;
    logic [4:0] br_op_q, br_op_d;
    logic       ir_write_q, ir_write_d;
    logic       pc_write_q, pc_write_d;
    logic       halted_q, halted_d;

    logic is_rtype, is_imm, is_lw, is_sw, is_br, is_bl, is_halt, is_illegal;

    // Instruction latch: capture opcode/func in DECODE, hold otherwise
    always_comb begin
        op_d   = op_q;
        func_d = func_q;
        if (state_q == S_DECODE) begin
            op_d   = opcode_out;
            func_d = func_out;
        end
    end

    // Opcode classification from the (about to be) latched instruction
    always_comb begin
        is_rtype   = (op_d == OP_RTYPE);
        is_imm     = (op_d == OP_ADDI) || (op_d == OP_COMPI);
        is_lw      = (op_d == OP_LW);
        is_sw      = (op_d == OP_SW);
        is_br      = (op_d >= OP_B) && (op_d <= OP_BNCY);
        is_bl      = (op_d == OP_BL);
        is_halt    = (op_d == HALT_OPCODE);
        is_illegal = (!(is_rtype || is_imm || is_lw || is_sw || is_br || is_halt))
                   || (is_rtype && (func_d[5:3] != 3'd0));
    end

    // Next-state, MEM latency counter and sticky trap flag
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_illegal) begin
`ifdef ILLEGAL_OP_TRAP_EN
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
`else
                    state_d   = S_WB;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    state_d = S_MEM;
                    cnt_d   = MEM_LOAD;
                end else if (is_br) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = is_lw ? S_WB : S_FETCH;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode for the state being entered, so outputs are registered
    always_comb begin
        reg_write_d = 2'b00;
        imm_mux_d   = 1'b0;
        alu_mux_d   = 1'b0;
        alu_op_d    = 4'd0;
        dmem_en_d   = 1'b0;
        dmem_we_d   = 1'b0;
        rw_mux_d    = 2'b00;
        br_op_d     = 5'd0;
        ir_write_d  = 1'b0;
        pc_write_d  = 1'b0;
        halted_d    = 1'b0;

        // ALU setup established in EXEC is held through MEM and WB
        if ((state_d == S_EXEC) || (state_d == S_MEM) || (state_d == S_WB)) begin
            if (is_rtype && !is_illegal) begin
                alu_op_d  = func_d[3:0];
                alu_mux_d = 1'b0;
            end else if (is_imm) begin
                alu_op_d  = (op_d == OP_COMPI) ? 4'd1 : 4'd0;
                alu_mux_d = 1'b1;
                imm_mux_d = 1'b0;
            end else if (is_lw || is_sw) begin
                alu_op_d  = 4'd0;
                alu_mux_d = 1'b1;
                imm_mux_d = 1'b1;
            end
        end

        case (state_d)
            S_FETCH: ir_write_d = 1'b1;
            S_EXEC: begin
                if (is_br) begin
                    br_op_d    = op_d[4:0];
                    pc_write_d = 1'b1;
                    if (is_bl) begin
                        reg_write_d = 2'b11;
                        rw_mux_d    = 2'b00;
                    end
                end
            end
            S_MEM: begin
                dmem_en_d  = 1'b1;
                dmem_we_d  = is_sw;
                pc_write_d = is_sw && (cnt_d == '0);
            end
            S_WB: begin
                pc_write_d = 1'b1;
                br_op_d    = 5'd0;
                if (is_lw) begin
                    reg_write_d = 2'b10;
                    rw_mux_d    = 2'b01;
                end else if (!is_illegal) begin
                    reg_write_d = 2'b01;
                    rw_mux_d    = 2'b10;
                end
            end
            S_HALT:  halted_d = 1'b1;
            default: ;
        endcase
    end

    // State, instruction latch, counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            func_q      <= '0;
            cnt_q       <= '0;
            illegal_q   <= 1'b0;
            reg_write_q <= 2'b00;
            imm_mux_q   <= 1'b0;
            alu_mux_q   <= 1'b0;
            alu_op_q    <= 4'd0;
            dmem_en_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            rw_mux_q    <= 2'b00;
            br_op_q     <= 5'd0;
            ir_write_q  <= 1'b0;
            pc_write_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            func_q      <= func_d;
            cnt_q       <= cnt_d;
            illegal_q   <= illegal_d;
            reg_write_q <= reg_write_d;
            imm_mux_q   <= imm_mux_d;
            alu_mux_q   <= alu_mux_d;
            alu_op_q    <= alu_op_d;
            dmem_en_q   <= dmem_en_d;
            dmem_we_q   <= dmem_we_d;
            rw_mux_q    <= rw_mux_d;
            br_op_q     <= br_op_d;
            ir_write_q  <= ir_write_d;
            pc_write_q  <= pc_write_d;
            halted_q    <= halted_d;
        end
    end

    assign reg_write          = reg_write_q;
    assign imm_mux_ctrl       = imm_mux_q;
    assign alu_mux_ctrl       = alu_mux_q;
    assign alu_op             = alu_op_q;
    assign dmem_enable        = dmem_en_q;
    assign dmem_write_enable  = dmem_we_q;
    assign reg_write_mux_ctrl = rw_mux_q;
    assign br_op              = br_op_q;
    assign ir_write           = ir_write_q;
    assign pc_write           = pc_write_q;
    assign halted             = halted_q;
    assign state_out          = state_q;
`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal_op         = illegal_q;
`endif

endmodule

// File: tb/tb_mini_risc_ctrl_fsm.sv
// Scoreboard bench for mini_risc_ctrl_fsm (MEM_LAT = 3): the stimulus process
// queues hand-computed per-cycle output vectors for each instruction, and an
// independent monitor pops one vector per cycle and compares all outputs.
module tb_mini_risc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode_out = 6'd0;
    logic [5:0] func_out = 6'd0;
    logic [1:0] reg_write;
    logic       imm_mux_ctrl;
    logic       alu_mux_ctrl;
    logic [3:0] alu_op;
    logic       dmem_enable;
    logic       dmem_write_enable;
    logic [1:0] reg_write_mux_ctrl;
    logic [4:0] br_op;
    logic       ir_write;
    logic       pc_write;
    logic       halted;
    logic [2:0] state_out;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       illegal_op;
`endif

    mini_risc_ctrl_fsm #(.MEM_LAT(3), .HALT_OPCODE(6'b111111)) dut (
        .clk(clk),
        .rst(rst),
        .opcode_out(opcode_out),
        .func_out(func_out),
        .reg_write(reg_write),
        .imm_mux_ctrl(imm_mux_ctrl),
        .alu_mux_ctrl(alu_mux_ctrl),
        .alu_op(alu_op),
        .dmem_enable(dmem_enable),
        .dmem_write_enable(dmem_write_enable),
        .reg_write_mux_ctrl(reg_write_mux_ctrl),
        .br_op(br_op),
        .ir_write(ir_write),
        .pc_write(pc_write),
        .halted(halted),
        .state_out(state_out)
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        .illegal_op(illegal_op)
`endif
    );

    always #5 clk = ~clk;

    // {state, halted, reg_write, imm_mux, alu_mux, alu_op, dmem_en, dmem_we, rw_mux, br_op, ir_write, pc_write}
    typedef struct packed {
        logic [2:0] st;
        logic       hlt;
        logic [1:0] rw;
        logic       imm;
        logic       amux;
        logic [3:0] aop;
        logic       den;
        logic       dwe;
        logic [1:0] rwm;
        logic [4:0] br;
        logic       ir;
        logic       pc;
    } vec_t;

    typedef struct {
        vec_t  v;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input int st, input int h, input int rw, input int im,
                                input int am, input int ao, input int de, input int dw,
                                input int rm, input int br, input int ir, input int pc);
        mk = {3'(st), 1'(h), 2'(rw), 1'(im), 1'(am), 4'(ao), 1'(de), 1'(dw),
              2'(rm), 5'(br), 1'(ir), 1'(pc)};
    endfunction

    task automatic push(input string tag, input vec_t v);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Common FETCH and DECODE cycles
    task automatic push_fd(input string tag);
        push({tag, "_fetch"},  mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        push({tag, "_decode"}, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // Wait until the monitor has consumed every queued vector; returns just after a rising edge
    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < 60)) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            $display("FAIL timeout %s: %0d vectors still pending, required 0", tag, exp_q.size());
            n_miss++;
            exp_q.delete();
        end
    endtask

    // Monitor: one comparison per cycle while expectations are queued
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            vec_t act;
            e   = exp_q.pop_front();
            act = {state_out, halted, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op,
                   dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op, ir_write, pc_write};
            n_vec++;
            if (act !== e.v) begin
                n_miss++;
                $display("FAIL %s: got st=%0d hlt=%b rw=%b imm=%b amux=%b aop=%0d den=%b dwe=%b rwm=%b br=%0d ir=%b pc=%b, required st=%0d hlt=%b rw=%b imm=%b amux=%b aop=%0d den=%b dwe=%b rwm=%b br=%0d ir=%b pc=%b",
                         e.tag, act.st, act.hlt, act.rw, act.imm, act.amux, act.aop, act.den,
                         act.dwe, act.rwm, act.br, act.ir, act.pc, e.v.st, e.v.hlt, e.v.rw,
                         e.v.imm, e.v.amux, e.v.aop, e.v.den, e.v.dwe, e.v.rwm, e.v.br,
                         e.v.ir, e.v.pc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Held in reset: everything low, state 0
        rst = 1'b0;
        push("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drain("reset");
        rst = 1'b1;

        // xor: states 0,1,2,3,5 then back to fetch
        opcode_out = 6'b000000;
        func_out   = 6'b000011;
        push("xor_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push_fd("xor");
        push("xor_exec", mk(3, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
        push("xor_wb",   mk(5, 0, 1, 0, 0, 3, 0, 0, 2, 0, 0, 1));
        drain("xor");

        // shra via R-type func 6
        opcode_out = 6'b000000;
        func_out   = 6'b000110;
        push_fd("shra");
        push("shra_exec", mk(3, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0));
        push("shra_wb",   mk(5, 0, 1, 0, 0, 6, 0, 0, 2, 0, 0, 1));
        drain("shra");

        // addi: immediate B operand, 4-cycle instruction
        opcode_out = 6'b000001;
        func_out   = 6'b111111;
        push_fd("addi");
        push("addi_exec", mk(3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        push("addi_wb",   mk(5, 0, 1, 0, 1, 0, 0, 0, 2, 0, 0, 1));
        drain("addi");

        // compi: ALU op 1
        opcode_out = 6'b000010;
        func_out   = 6'b000000;
        push_fd("compi");
        push("compi_exec", mk(3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        push("compi_wb",   mk(5, 0, 1, 0, 1, 1, 0, 0, 2, 0, 0, 1));
        drain("compi");

        // sw with MEM_LAT=3: three write cycles, pc_write on the last
        opcode_out = 6'b000100;
        push_fd("sw");
        push("sw_exec", mk(3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        push("sw_mem1", mk(4, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0));
        push("sw_mem2", mk(4, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0));
        push("sw_mem3", mk(4, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 1));
        drain("sw");

        // lw with MEM_LAT=3: reads only, then writeback from memory
        opcode_out = 6'b000011;
        push_fd("lw");
        push("lw_exec", mk(3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        push("lw_mem1", mk(4, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0));
        push("lw_mem2", mk(4, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0));
        push("lw_mem3", mk(4, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0));
        push("lw_wb",   mk(5, 0, 2, 1, 1, 0, 0, 0, 1, 0, 0, 1));
        drain("lw");

        // bl: branch plus link write in EXEC, 3 cycles
        opcode_out = 6'b001010;
        push_fd("bl");
        push("bl_exec", mk(3, 0, 3, 0, 0, 0, 0, 0, 0, 10, 0, 1));
        drain("bl");

        // bz: plain branch, no link
        opcode_out = 6'b001000;
        push_fd("bz");
        push("bz_exec", mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 1));
        drain("bz");

`ifndef ILLEGAL_OP_TRAP_EN
        // Undefined opcode retires as a NOP straight from decode
        opcode_out = 6'b001101;
        push_fd("nop");
        push("nop_wb", mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        drain("nop");
`endif

        // Halt opcode: halted held for 10 cycles
        opcode_out = 6'b111111;
        push_fd("halt");
        for (int i = 0; i < 10; i++) begin
            push("halt_hold", mk(7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        drain("halt");

        // Only reset leaves halt
        rst = 1'b0;
        push("halt_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drain("halt_reset");
        rst = 1'b1;

        // sw, then drop reset mid-MEM between clock edges
        opcode_out = 6'b000100;
        push("sw2_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push_fd("sw2");
        push("sw2_exec", mk(3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        push("sw2_mem1", mk(4, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0));
        drain("sw2");
        push("async_reset_mid_mem", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        rst = 1'b0;
        drain("async_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
